seg_scan_ctrl: RTL
==================

# seg_scan_ctrl

Time-multiplexed scan controller for a common-anode multi-digit 7-segment display. It holds an NDIG-digit hex value and cycles one digit at a time onto a shared hex nibble, which feeds the team's combinational hex-to-7-segment decoder. It drives the matching active-low anode line, inserts an all-off guard interval between digits to suppress ghosting, and applies leading-zero suppression and per-digit blanking. Display updates are frame-coherent: a new value is never shown torn across a scan.

## Interface
- NDIG, 4: number of digits, 2..8; digit 0 is least significant.
- DIV, 50000: clock cycles each digit is lit; must be at least 1.
- GUARD, 16: all-off clock cycles between digits; 0 allowed.
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- value  in  4*NDIG  hex digits; nibble i is value[4i+3:4i].
- load  in  1  single-cycle strobe that captures value into the pending register.
- lz  in  1  leading-zero suppression enable, level-sampled every cycle.
- blank_mask  in  NDIG  bit i=1 forces digit i off, level-sampled.
- dp_in  in  NDIG  decimal point per digit, level-sampled.
- hex_out  out  4  nibble to the decoder.
- seg_en  out  1  1 = decoder output valid/lit; 0 = segments must be off.
- an  out  NDIG  anode enables, active-low, at most one bit low.
- dp  out  1  decimal point for the lit digit, active-high.
- frame_start  out  1  one-cycle pulse on entry to SHOW for digit 0.

## Operation
- Registers:
  - state: SHOW or GUARD.
  - idx: 0..NDIG-1.
  - cnt: wide enough for max(DIV, GUARD).
  - pend: 4*NDIG bits, plus a pend_v flag.
  - act: 4*NDIG bits, the value currently displayed.
- Load: load=1 sets pend<=value and pend_v<=1. A second load before the next frame overwrites pend; last write wins.
- Frame update: on each entry to SHOW with idx=0, if pend_v=1 then act<=pend and pend_v<=0.
  - If load=1 in that same cycle, the value on the value port is copied to act directly, and pend_v is left 0.
- FSM:
  - SHOW: cnt counts 0..DIV-1. At DIV-1, idx<=(idx==NDIG-1)?0:idx+1 and cnt<=0. The next state is GUARD if GUARD>0, otherwise SHOW for the new idx.
  - GUARD: cnt counts 0..GUARD-1. At GUARD-1, the next state is SHOW with cnt<=0 and idx unchanged.
- Digit k is suppressed when blank_mask[k]=1, or when lz=1, k>0, and act nibbles NDIG-1..k are all zero. Digit 0 is never lz-suppressed.
- Outputs are registered and change on the same edge as state and idx.
  - SHOW, digit not suppressed: an=~(1<<idx), hex_out=act nibble idx, seg_en=1, dp=dp_in[idx].
  - SHOW, digit suppressed: an all ones, seg_en=0, dp=0. hex_out still carries the nibble.
  - GUARD: an all ones, seg_en=0, dp=0. hex_out holds its last value.
- lz, blank_mask and dp_in are evaluated every SHOW cycle, so a change takes effect on the next edge.

## Timing
- Reset, asynchronous: state=GUARD, idx=0, cnt=0, pend=0, pend_v=0, act=0, an all ones, hex_out=0, seg_en=0, dp=0, frame_start=0.
- With GUARD=0, reset enters SHOW for digit 0 on the first edge.
- First SHOW of digit 0 begins GUARD cycles after reset release.
- Per-digit period is DIV+GUARD cycles. Frame period is NDIG*(DIV+GUARD) cycles.
- Load-to-display latency runs from the load edge to the next frame_start edge: from 1 cycle up to one frame period.
- frame_start is high for exactly the first cycle of SHOW with idx=0.
- Reset asserted mid-scan: all outputs return to their reset values immediately, without waiting for a clock edge. Any pending load is discarded.
- an is never low in two positions, and never low during GUARD.

## Test plan
- Reset and scan: NDIG=4, DIV=4, GUARD=1. Load 16'h1234 right after reset, then run 2 frames.
  - Required: frame_start once every 20 cycles.
  - Required per frame: an 1110/1101/1011/0111, each for 4 cycles, with hex_out 4, 3, 2, 1.
  - Required: an=1111 for 1 cycle between digits.
- Frame coherence: act=16'h1234, load 16'hABCD in the middle of digit 2's SHOW.
  - Required: digits 2 and 3 still show 2 and 1.
  - Required: the next frame shows D, C, B, A.
- Leading zeros: load 16'h0050, lz=1.
  - Required: digit 0 shows 0 and digit 1 shows 5, both with seg_en=1.
  - Required: digits 2 and 3 have an=1111 and seg_en=0.
  - With lz=0: all 4 digits are lit.
- Mask and dp: blank_mask=4'b0010, dp_in=4'b0100.
  - Required: digit 1 is never lit.
  - Required: dp=1 only while an=1011.
- Reset mid-SHOW of digit 2 with a load pending.
  - Required: outputs are at reset values immediately.
  - Required: after release, the first frame shows act=0, i.e. four zeros.
- GUARD=0, DIV=1:
  - Required: an changes digit on every cycle and is never 1111 after the first edge.
  - Required: frame_start pulses every 4 cycles.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Scan controller for a common-anode multi-digit 7-segment display.
// Lights one digit at a time with an all-off guard gap between digits.
// Applies leading-zero suppression and per-digit blanking.
// New values are latched into the displayed register only at frame start,
// so a single scan never mixes digits from two different values.
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_SHOW  | digit idx driven for DIV cycles (cnt 0..DIV-1)
// ST_GUARD | all anodes off for GUARD cycles (cnt 0..GUARD-1)
module seg_scan_ctrl #(
  parameter int NDIG  = 4,
  parameter int DIV   = 50000,
  parameter int GUARD = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4*NDIG-1:0] value,
  input  logic              load,
  input  logic              lz,
  input  logic [NDIG-1:0]   blank_mask,
  input  logic [NDIG-1:0]   dp_in,
  output logic [3:0]        hex_out,
  output logic              seg_en,
  output logic [NDIG-1:0]   an,
  output logic              dp,
  output logic              frame_start
);

  localparam int CMAX = (DIV > GUARD) ? DIV : GUARD;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int IW   = $clog2(NDIG);

  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'((GUARD > 0) ? GUARD - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);

  typedef enum logic {ST_SHOW, ST_GUARD} state_t;

  state_t            state, state_nxt;
  logic [IW-1:0]     idx, idx_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [4*NDIG-1:0] pend, act, act_nxt;
  logic              pend_v;
  logic              enter_show, frame_upd;
  logic [NDIG-1:0]   lz_sup;
  logic              allz, sup_nxt, dp_nxt;
  logic [3:0]        nib_nxt;

  // State, digit index and dwell counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_GUARD;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; enter_show flags every transition into SHOW.
  // With GUARD=0 the GUARD state collapses to a single pass-through edge.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    cnt_nxt    = cnt + 1'b1;
    enter_show = 1'b0;
    case (state)
      ST_SHOW: begin
        if (cnt == DIV_LAST) begin
          cnt_nxt = '0;
          idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
          if (GUARD > 0) begin
            state_nxt = ST_GUARD;
          end else begin
            state_nxt  = ST_SHOW;
            enter_show = 1'b1;
          end
        end
      end
      ST_GUARD: begin
        if ((GUARD == 0) || (cnt == GUARD_LAST)) begin
          cnt_nxt    = '0;
          state_nxt  = ST_SHOW;
          enter_show = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_GUARD;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Frame-coherent update: a load coinciding with frame start bypasses pend.
  always_comb begin
    frame_upd = enter_show && (idx_nxt == '0);
    act_nxt   = act;
    if (frame_upd) begin
      if (load) begin
        act_nxt = value;
      end else if (pend_v) begin
        act_nxt = pend;
      end
    end
  end

  // Suppression and per-digit selection, evaluated for the digit shown after the edge.
  always_comb begin
    allz    = 1'b1;
    lz_sup  = '0;
    nib_nxt = 4'h0;
    sup_nxt = 1'b0;
    dp_nxt  = 1'b0;
    for (int k = NDIG - 1; k >= 0; k--) begin
      allz      = allz & (act_nxt[4*k +: 4] == 4'h0);
      lz_sup[k] = lz & (k > 0) & allz;
    end
    for (int k = 0; k < NDIG; k++) begin
      if (idx_nxt == IW'(k)) begin
        nib_nxt = act_nxt[4*k +: 4];
        sup_nxt = blank_mask[k] | lz_sup[k];
        dp_nxt  = dp_in[k];
      end
    end
  end

  // Value registers and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend        <= '0;
      pend_v      <= 1'b0;
      act         <= '0;
      an          <= '1;
      hex_out     <= 4'h0;
      seg_en      <= 1'b0;
      dp          <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      act         <= act_nxt;
      frame_start <= frame_upd;
      if (frame_upd) begin
        pend_v <= 1'b0;
      end else if (load) begin
        pend   <= value;
        pend_v <= 1'b1;
      end
      if (state_nxt == ST_SHOW) begin
        hex_out <= nib_nxt;
        if (sup_nxt) begin
          an     <= '1;
          seg_en <= 1'b0;
          dp     <= 1'b0;
        end else begin
          an     <= ~(NDIG'(1) << idx_nxt);
          seg_en <= 1'b1;
          dp     <= dp_nxt;
        end
      end else begin
        an     <= '1;
        seg_en <= 1'b0;
        dp     <= 1'b0;
      end
    end
  end

endmodule
